// File: rtl/map_scroll_ctl_pkg.sv
// Shared game-side types and constants for the horizontal map scroller.
package map_scroll_ctl_pkg;

  typedef enum logic [1:0] {IDLE, MOVING, BRAKING} scroll_state_t;

  localparam int unsigned POS_FRAC_BITS = 4;
  localparam int unsigned MAP_VIS_W     = 256;

endpackage

// File: rtl/map_scroll_ctl_if.sv
// Frame/button inputs and offset outputs exchanged between game logic and scroller.
interface map_scroll_ctl_if;

  logic       vblnk;
  logic       move_left;
  logic       move_right;
  logic       enable;
  logic [7:0] map_ofset;
  logic       frame_tick;
  logic       moving;

  modport master (
    output vblnk, move_left, move_right, enable,
    input  map_ofset, frame_tick, moving
  );

  modport slave (
    input  vblnk, move_left, move_right, enable,
    output map_ofset, frame_tick, moving
  );

endinterface

// File: rtl/map_scroll_ctl_edge_tick.sv
// Registered one-cycle pulse on each rising edge of sig.
module map_scroll_ctl_edge_tick (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);

  logic sig_d;

  // sig_d tracks sig even in reset, so a level already high at release is not an edge.
  always_ff @(posedge clk) begin
    sig_d <= sig;
    if (rst) pulse <= 1'b0;
    else     pulse <= sig & ~sig_d;
  end

endmodule

// File: rtl/map_scroll_ctl.sv
// Frame-rate horizontal scroll integrator: velocity with accel/braking, 8.4 position.
module map_scroll_ctl
  import map_scroll_ctl_pkg::*;
#(
  parameter int ACC      = 2,
  parameter int DEC      = 1,
  parameter int MAX_VEL  = 32,
  parameter int OFS_MAX  = int'(MAP_VIS_W) - 1,
  parameter int INIT_OFS = 0
) (
  input  logic clk,
  input  logic rst,
  map_scroll_ctl_if.slave bus
);

  localparam int             FRAC_SCALE = 2 ** POS_FRAC_BITS;
  localparam int             POS_MAX    = OFS_MAX * FRAC_SCALE + FRAC_SCALE - 1;
  localparam logic [11:0]    POS_INIT   = 12'(INIT_OFS * FRAC_SCALE);

  scroll_state_t      state, state_nxt;
  logic signed [6:0]  vel, vel_nxt, vel_c;
  logic [11:0]        pos, pos_nxt;
  logic [7:0]         ofs;
  logic               mov;
  logic               tick;
  logic               right_only, left_only, single, sat;
  logic signed [8:0]  v_acc;
  logic signed [13:0] p_sum;

  map_scroll_ctl_edge_tick u_tick (
    .clk   (clk),
    .rst   (rst),
    .sig   (bus.vblnk),
    .pulse (tick)
  );

  always_comb begin
    right_only = bus.move_right & ~bus.move_left;
    left_only  = bus.move_left & ~bus.move_right;
    single     = right_only | left_only;
    v_acc      = 9'(vel);
    if (right_only) begin
      v_acc = 9'(vel) + 9'(ACC);
      if (v_acc > 9'(MAX_VEL)) v_acc = 9'(MAX_VEL);
    end else if (left_only) begin
      v_acc = 9'(vel) - 9'(ACC);
      if (v_acc < -9'(MAX_VEL)) v_acc = -9'(MAX_VEL);
    end else if (vel > 7'sd0) begin
      v_acc = 9'(vel) - 9'(DEC);
      if (v_acc < 9'sd0) v_acc = '0;
    end else if (vel < 7'sd0) begin
      v_acc = 9'(vel) + 9'(DEC);
      if (v_acc > 9'sd0) v_acc = '0;
    end
    vel_c = 7'(v_acc);

    p_sum   = $signed({2'b00, pos}) + 14'(vel_c);
    sat     = 1'b0;
    pos_nxt = p_sum[11:0];
    vel_nxt = vel_c;
    if (p_sum < 14'sd0) begin
      sat     = 1'b1;
      pos_nxt = '0;
      vel_nxt = '0;
    end else if (p_sum > 14'(POS_MAX)) begin
      sat     = 1'b1;
      pos_nxt = 12'(POS_MAX);
      vel_nxt = '0;
    end
    if (!bus.enable) begin
      vel_nxt = '0;
      pos_nxt = pos;
    end

    // Saturation with no direction held lands in IDLE via vel_nxt == 0.
    state_nxt = state;
    if (!bus.enable)            state_nxt = IDLE;
    else if (single)            state_nxt = MOVING;
    else if (vel_nxt == 7'sd0)  state_nxt = IDLE;
    else                        state_nxt = BRAKING;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vel   <= '0;
      pos   <= POS_INIT;
      ofs   <= POS_INIT[11:4];
      mov   <= 1'b0;
    end else if (tick) begin
      state <= state_nxt;
      vel   <= vel_nxt;
      pos   <= pos_nxt;
      ofs   <= pos_nxt[11:4];
      mov   <= (vel_nxt != 7'sd0);
    end
  end

  assign bus.frame_tick = tick;
  assign bus.map_ofset  = ofs;
  assign bus.moving     = mov;

  logic unused_sat;
  assign unused_sat = sat;

endmodule

// File: tb/tb_map_scroll_ctl.sv
// Directed bench for map_scroll_ctl: reset, ramp, braking, saturation, enable, mid-motion reset.
module tb_map_scroll_ctl;
  import map_scroll_ctl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  map_scroll_ctl_if bus();

  map_scroll_ctl #(
    .ACC(2), .DEC(1), .MAX_VEL(32), .OFS_MAX(255), .INIT_OFS(0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic       ft_e0;
  logic [7:0] ofs_e0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.vblnk = 1'b0; bus.move_left = 1'b0; bus.move_right = 1'b0; bus.enable = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One frame: vblnk rises, tick seen one clock later, update one clock after that.
  task automatic do_tick();
    @(negedge clk); bus.vblnk = 1'b1;
    @(negedge clk); ft_e0 = bus.frame_tick; ofs_e0 = bus.map_ofset;
    @(negedge clk); bus.vblnk = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int cnt;
    apply_reset();
    checks++; if (bus.map_ofset !== 8'd0) begin errors++; $display("FAIL reset_ofs: got %0d want 0", bus.map_ofset); end
    checks++; if (bus.moving !== 1'b0) begin errors++; $display("FAIL reset_moving: got %b want 0", bus.moving); end
    checks++; if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", bus.frame_tick); end
    cnt = 0;
    @(negedge clk); bus.vblnk = 1'b1;
    for (int i = 0; i < 10; i++) begin @(negedge clk); cnt += int'(bus.frame_tick); end
    bus.vblnk = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); cnt += int'(bus.frame_tick); end
    checks++; if (cnt != 1) begin errors++; $display("FAIL long_vblnk_ticks: got %0d want 1", cnt); end
  endtask

  task automatic test_accel();
    apply_reset();
    bus.move_right = 1'b1;
    do_tick();
    checks++; if (dut.vel !== 7'sd2 || dut.pos !== 12'd2) begin errors++; $display("FAIL accel_t1: got vel=%0d pos=%0d want 2/2", dut.vel, dut.pos); end
    do_tick();
    checks++; if (dut.vel !== 7'sd4 || dut.pos !== 12'd6) begin errors++; $display("FAIL accel_t2: got vel=%0d pos=%0d want 4/6", dut.vel, dut.pos); end
    do_tick();
    checks++; if (dut.vel !== 7'sd6 || dut.pos !== 12'd12 || bus.map_ofset !== 8'd0) begin errors++; $display("FAIL accel_t3: got vel=%0d pos=%0d ofs=%0d want 6/12/0", dut.vel, dut.pos, bus.map_ofset); end
    do_tick();
    checks++; if (ft_e0 !== 1'b1 || ofs_e0 !== 8'd0) begin errors++; $display("FAIL latency_pre: got tick=%b ofs=%0d want 1/0", ft_e0, ofs_e0); end
    checks++; if (bus.map_ofset !== 8'd1) begin errors++; $display("FAIL latency_post: got %0d want 1", bus.map_ofset); end
    repeat (12) do_tick();
    checks++; if (dut.vel !== 7'sd32 || dut.pos !== 12'd272) begin errors++; $display("FAIL accel_t16: got vel=%0d pos=%0d want 32/272", dut.vel, dut.pos); end
    checks++; if (bus.map_ofset !== 8'd17 || bus.moving !== 1'b1) begin errors++; $display("FAIL accel_t16_out: got ofs=%0d mov=%b want 17/1", bus.map_ofset, bus.moving); end
  endtask

  task automatic test_brake();
    bus.move_right = 1'b0;
    do_tick();
    checks++; if (dut.vel !== 7'sd31 || dut.state !== BRAKING || bus.moving !== 1'b1) begin errors++; $display("FAIL brake_t1: got vel=%0d st=%0d mov=%b want 31/BRAKING/1", dut.vel, dut.state, bus.moving); end
    repeat (30) do_tick();
    checks++; if (dut.vel !== 7'sd1 || bus.moving !== 1'b1) begin errors++; $display("FAIL brake_t31: got vel=%0d mov=%b want 1/1", dut.vel, bus.moving); end
    do_tick();
    checks++; if (dut.vel !== 7'sd0 || bus.moving !== 1'b0 || dut.state !== IDLE) begin errors++; $display("FAIL brake_stop: got vel=%0d mov=%b st=%0d want 0/0/IDLE", dut.vel, bus.moving, dut.state); end
    checks++; if (dut.pos !== 12'd768 || bus.map_ofset !== 8'd48) begin errors++; $display("FAIL brake_dist: got pos=%0d ofs=%0d want 768/48", dut.pos, bus.map_ofset); end
  endtask

  task automatic test_saturation();
    apply_reset();
    bus.move_left = 1'b1;
    do_tick();
    checks++; if (dut.pos !== 12'd0 || dut.vel !== 7'sd0) begin errors++; $display("FAIL sat_lo: got pos=%0d vel=%0d want 0/0", dut.pos, dut.vel); end
    checks++; if (bus.map_ofset !== 8'd0 || bus.moving !== 1'b0) begin errors++; $display("FAIL sat_lo_out: got ofs=%0d mov=%b want 0/0", bus.map_ofset, bus.moving); end
    bus.move_left = 1'b0; bus.move_right = 1'b1;
    repeat (135) do_tick();
    checks++; if (dut.pos !== 12'd4080 || dut.vel !== 7'sd32) begin errors++; $display("FAIL sat_hi_pre: got pos=%0d vel=%0d want 4080/32", dut.pos, dut.vel); end
    do_tick();
    checks++; if (dut.pos !== 12'd4095 || dut.vel !== 7'sd0) begin errors++; $display("FAIL sat_hi: got pos=%0d vel=%0d want 4095/0", dut.pos, dut.vel); end
    checks++; if (bus.map_ofset !== 8'd255 || bus.moving !== 1'b0) begin errors++; $display("FAIL sat_hi_out: got ofs=%0d mov=%b want 255/0", bus.map_ofset, bus.moving); end
  endtask

  task automatic test_both_toggle();
    apply_reset();
    bus.move_right = 1'b1;
    repeat (5) do_tick();
    checks++; if (dut.vel !== 7'sd10 || dut.pos !== 12'd30) begin errors++; $display("FAIL both_setup: got vel=%0d pos=%0d want 10/30", dut.vel, dut.pos); end
    bus.move_left = 1'b1;
    do_tick();
    checks++; if (dut.vel !== 7'sd9 || dut.pos !== 12'd39) begin errors++; $display("FAIL both_t1: got vel=%0d pos=%0d want 9/39", dut.vel, dut.pos); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); bus.move_left = 1'b0;
      repeat (2) @(negedge clk); bus.move_left = 1'b1; bus.move_right = 1'b0;
      repeat (2) @(negedge clk); bus.move_right = 1'b1;
      do_tick();
    end
    checks++; if (dut.vel !== 7'sd7 || dut.pos !== 12'd54) begin errors++; $display("FAIL toggle_ignored: got vel=%0d pos=%0d want 7/54", dut.vel, dut.pos); end
    checks++; if (bus.map_ofset !== 8'd3 || bus.moving !== 1'b1) begin errors++; $display("FAIL toggle_out: got ofs=%0d mov=%b want 3/1", bus.map_ofset, bus.moving); end
  endtask

  task automatic test_enable();
    apply_reset();
    bus.move_right = 1'b1;
    repeat (10) do_tick();
    checks++; if (dut.vel !== 7'sd20 || bus.map_ofset !== 8'd6) begin errors++; $display("FAIL en_setup: got vel=%0d ofs=%0d want 20/6", dut.vel, bus.map_ofset); end
    bus.enable = 1'b0;
    do_tick();
    checks++; if (dut.vel !== 7'sd0 || dut.pos !== 12'd110 || bus.map_ofset !== 8'd6) begin errors++; $display("FAIL en_freeze: got vel=%0d pos=%0d ofs=%0d want 0/110/6", dut.vel, dut.pos, bus.map_ofset); end
    checks++; if (bus.moving !== 1'b0 || dut.state !== IDLE) begin errors++; $display("FAIL en_idle: got mov=%b st=%0d want 0/IDLE", bus.moving, dut.state); end
    do_tick();
    checks++; if (dut.pos !== 12'd110) begin errors++; $display("FAIL en_hold: got pos=%0d want 110", dut.pos); end
    bus.enable = 1'b1; bus.move_right = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cnt;
    apply_reset();
    bus.move_right = 1'b1;
    repeat (12) do_tick();
    checks++; if (bus.map_ofset !== 8'd9 || dut.vel !== 7'sd24) begin errors++; $display("FAIL mid_setup: got ofs=%0d vel=%0d want 9/24", bus.map_ofset, dut.vel); end
    @(negedge clk); rst = 1'b1; bus.vblnk = 1'b1; bus.move_right = 1'b0;
    @(negedge clk);
    checks++; if (bus.map_ofset !== 8'd0 || bus.moving !== 1'b0 || dut.vel !== 7'sd0) begin errors++; $display("FAIL mid_reset: got ofs=%0d mov=%b vel=%0d want 0/0/0", bus.map_ofset, bus.moving, dut.vel); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); cnt += int'(bus.frame_tick); end
    checks++; if (cnt != 0) begin errors++; $display("FAIL high_at_release: got %0d ticks want 0", cnt); end
    bus.vblnk = 1'b0;
    repeat (2) @(negedge clk);
    bus.vblnk = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); cnt += int'(bus.frame_tick); end
    checks++; if (cnt != 1) begin errors++; $display("FAIL fresh_edge: got %0d ticks want 1", cnt); end
    bus.vblnk = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.vblnk = 1'b0; bus.move_left = 1'b0; bus.move_right = 1'b0; bus.enable = 1'b1;
    test_reset();
    test_accel();
    test_brake();
    test_saturation();
    test_both_toggle();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
